// File: rtl/password_store_ctrl.sv
// password_store_ctrl: owns the password memory and arbitrates access to it.
// The access checker reads password slots through rd_req/rd_valid. A
// reconfiguration captures a new 4-digit BCD password from the switches,
// writes it to the selected slot, then reads the slot back to verify the
// write.
module password_store_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_slot,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              reconfig,
  input  logic [ADDR_W-1:0] wr_slot,
  input  logic [3:0]        digit,
  input  logic              digit_enter,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              capturing,
  output logic              wr_done,
  output logic              wr_ok,
  output logic              bad_digit
);

  localparam int NDIG  = DATA_W / 4;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [2:0] READ_CNT_INIT   = 3'(RD_LAT);
  localparam logic [2:0] VERIFY_CNT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    READ_WAIT,
    WRITE,
    VERIFY_WAIT,
    VERIFY
  } state_t;

  state_t            state_q, state_d;
  logic              ret_cap_q, ret_cap_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] slot_q, slot_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              pend_q, pend_d;
  logic              buf_valid_q, buf_valid_d;
  logic [3:0]        buf_digit_q, buf_digit_d;
  logic              capturing_q, capturing_d;
  logic              wr_done_q, wr_done_d;
  logic              wr_ok_q, wr_ok_d;
  logic              bad_digit_q, bad_digit_d;

  logic              take_digit;
  logic [3:0]        digit_val;
  logic              read_ok;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      ret_cap_q   <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      slot_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      idx_q       <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_digit_q <= '0;
      capturing_q <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_ok_q     <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_cap_q   <= ret_cap_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      slot_q      <= slot_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      buf_valid_q <= buf_valid_d;
      buf_digit_q <= buf_digit_d;
      capturing_q <= capturing_d;
      wr_done_q   <= wr_done_d;
      wr_ok_q     <= wr_ok_d;
      bad_digit_q <= bad_digit_d;
    end
  end

  // Next-state and datapath update; a read is never accepted in the rd_valid
  // cycle so a requester that drops rd_req on rd_valid gets exactly one read.
  always_comb begin
    state_d     = state_q;
    ret_cap_d   = ret_cap_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    slot_d      = slot_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    idx_d       = idx_q;
    word_d      = word_q;
    pend_d      = pend_q;
    buf_valid_d = buf_valid_q;
    buf_digit_d = buf_digit_q;
    capturing_d = capturing_q;
    wr_done_d   = 1'b0;
    wr_ok_d     = wr_ok_q;
    bad_digit_d = 1'b0;
    take_digit  = 1'b0;
    digit_val   = digit;
    read_ok     = rd_req && !rd_valid_q;

    case (state_q)
      IDLE: begin
        if (reconfig) begin
          slot_d = wr_slot;
        end
        if (read_ok) begin
          mem_addr_d = rd_slot;
          ret_cap_d  = 1'b0;
          cnt_d      = READ_CNT_INIT;
          state_d    = READ_WAIT;
          if (reconfig) begin
            pend_d = 1'b1;
          end
        end else if (reconfig || pend_q) begin
          state_d     = CAPTURE;
          pend_d      = 1'b0;
          idx_d       = '0;
          word_d      = '0;
          buf_valid_d = 1'b0;
          capturing_d = 1'b1;
        end
      end

      CAPTURE: begin
        if (reconfig || pend_q) begin
          if (reconfig) begin
            slot_d = wr_slot;
          end
          pend_d      = 1'b0;
          idx_d       = '0;
          word_d      = '0;
          buf_valid_d = 1'b0;
        end else begin
          if (buf_valid_q) begin
            take_digit  = 1'b1;
            digit_val   = buf_digit_q;
            buf_valid_d = 1'b0;
          end else if (digit_enter) begin
            take_digit = 1'b1;
          end
          if (take_digit) begin
            if (digit_val > 4'd9) begin
              bad_digit_d = 1'b1;
              idx_d       = '0;
              word_d      = '0;
            end else begin
              for (int n = 0; n < NDIG; n++) begin
                if (idx_q == IDX_W'(n)) begin
                  word_d[DATA_W-1-4*n -: 4] = digit_val;
                end
              end
              if (idx_q == LAST_IDX) begin
                idx_d      = '0;
                mem_addr_d = slot_q;
                state_d    = WRITE;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
        if (state_d == CAPTURE && read_ok) begin
          mem_addr_d = rd_slot;
          ret_cap_d  = 1'b1;
          cnt_d      = READ_CNT_INIT;
          state_d    = READ_WAIT;
        end
      end

      READ_WAIT: begin
        if (reconfig) begin
          pend_d = 1'b1;
          slot_d = wr_slot;
        end
        if (digit_enter && ret_cap_q && !buf_valid_q) begin
          buf_valid_d = 1'b1;
          buf_digit_d = digit;
        end
        if (cnt_q == 3'd0) begin
          rd_data_d  = mem_rdata;
          rd_valid_d = 1'b1;
          state_d    = ret_cap_q ? CAPTURE : IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      WRITE: begin
        capturing_d = 1'b0;
        cnt_d       = VERIFY_CNT_INIT;
        state_d     = VERIFY_WAIT;
      end

      VERIFY_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = VERIFY;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      VERIFY: begin
        wr_ok_d   = (mem_rdata == word_q);
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; the memory write strobe exists only in the WRITE state.
  always_comb begin
    mem_we    = (state_q == WRITE);
    mem_wdata = mem_we ? word_q : '0;
    busy      = (state_q != IDLE);
    mem_addr  = mem_addr_q;
    rd_valid  = rd_valid_q;
    rd_data   = rd_data_q;
    capturing = capturing_q;
    wr_done   = wr_done_q;
    wr_ok     = wr_ok_q;
    bad_digit = bad_digit_q;
  end

endmodule

// File: tb/tb_password_store_ctrl.sv
// tb_password_store_ctrl: directed bench for password_store_ctrl with a
// small latency-accurate memory model. Expected values are hand-computed.
module tb_password_store_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int RD_LAT = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_slot = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              reconfig = 1'b0;
  logic [ADDR_W-1:0] wr_slot = '0;
  logic [3:0]        digit = '0;
  logic              digit_enter = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              capturing;
  logic              wr_done;
  logic              wr_ok;
  logic              bad_digit;

  logic              mem_init = 1'b1;
  logic              corrupt = 1'b0;
  logic [DATA_W-1:0] mem [4];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  int                we_count = 0;
  int                we_base;
  int                checks = 0;
  int                errors = 0;

  password_store_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rd_req(rd_req),
    .rd_slot(rd_slot),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .reconfig(reconfig),
    .wr_slot(wr_slot),
    .digit(digit),
    .digit_enter(digit_enter),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .capturing(capturing),
    .wr_done(wr_done),
    .wr_ok(wr_ok),
    .bad_digit(bad_digit)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Memory model: registered write, RD_LAT-stage read pipeline.
  always @(posedge clock) begin
    if (mem_init) begin
      mem[0] <= 16'h2949;
      mem[1] <= 16'h0000;
      mem[2] <= 16'h0000;
      mem[3] <= 16'h0000;
    end else if (mem_we) begin
      mem[mem_addr] <= corrupt ? 16'h0000 : mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Count write strobes to prove each write is exactly one cycle.
  always @(posedge clock) begin
    if (mem_we) begin
      we_count <= we_count + 1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic rq, input logic [ADDR_W-1:0] rs,
                               input logic rc, input logic [ADDR_W-1:0] ws,
                               input logic [3:0] d, input logic de);
    rd_req      = rq;
    rd_slot     = rs;
    reconfig    = rc;
    wr_slot     = ws;
    digit       = d;
    digit_enter = de;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 4'h0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with memory preload.
    @(posedge clock);
    #1;
    idleCycles(2);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_capturing", 32'(capturing), 32'h0);
    checkOutput("rst_wr_done_ok", 32'({wr_done, wr_ok, bad_digit}), 32'h0);
    reset    = 1'b1;
    mem_init = 1'b0;

    // 1: plain read of slot 0, rd_valid 3 cycles after acceptance.
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    checkOutput("t1_addr", 32'(mem_addr), 32'h0);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t1_valid_early1", 32'(rd_valid), 32'h0);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t1_valid_early2", 32'(rd_valid), 32'h0);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t1_valid", 32'(rd_valid), 32'h1);
    checkOutput("t1_data", 32'(rd_data), 32'h2949);
    idleCycles(1);
    checkOutput("t1_valid_pulse", 32'(rd_valid), 32'h0);
    checkOutput("t1_idle", 32'(busy), 32'h0);
    checkOutput("t1_data_hold", 32'(rd_data), 32'h2949);

    // 2: capture 1,2,3,4 into slot 1 and verify.
    we_base = we_count;
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 4'h0, 1'b0);
    checkOutput("t2_capturing", 32'(capturing), 32'h1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h2, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h3, 1'b1);
    checkOutput("t2_no_early_we", 32'(mem_we), 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h4, 1'b1);
    checkOutput("t2_we", 32'(mem_we), 32'h1);
    checkOutput("t2_addr", 32'(mem_addr), 32'h1);
    checkOutput("t2_wdata", 32'(mem_wdata), 32'h1234);
    idleCycles(1);
    checkOutput("t2_we_single", 32'(mem_we), 32'h0);
    checkOutput("t2_capt_clear", 32'(capturing), 32'h0);
    checkOutput("t2_addr_hold", 32'(mem_addr), 32'h1);
    idleCycles(2);
    checkOutput("t2_done_early", 32'(wr_done), 32'h0);
    idleCycles(1);
    checkOutput("t2_done", 32'(wr_done), 32'h1);
    checkOutput("t2_ok", 32'(wr_ok), 32'h1);
    checkOutput("t2_mem_slot1", 32'(mem[1]), 32'h1234);
    idleCycles(1);
    checkOutput("t2_done_pulse", 32'(wr_done), 32'h0);
    checkOutput("t2_ok_hold", 32'(wr_ok), 32'h1);
    checkOutput("t2_we_count", 32'(we_count - we_base), 32'h1);

    // 3: bad digit restarts capture; then 7,8,9,0 into slot 2.
    we_base = we_count;
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, 4'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h5, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h6, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'hA, 1'b1);
    checkOutput("t3_bad", 32'(bad_digit), 32'h1);
    checkOutput("t3_still_capt", 32'(capturing), 32'h1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h7, 1'b1);
    checkOutput("t3_bad_pulse", 32'(bad_digit), 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h8, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h9, 1'b1);
    checkOutput("t3_no_we", 32'(we_count - we_base), 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h0, 1'b1);
    checkOutput("t3_we", 32'(mem_we), 32'h1);
    checkOutput("t3_addr", 32'(mem_addr), 32'h2);
    checkOutput("t3_wdata", 32'(mem_wdata), 32'h7890);
    idleCycles(4);
    checkOutput("t3_done_ok", 32'({wr_done, wr_ok}), 32'h3);

    // 4: read during capture with a buffered digit.
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd3, 4'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h2, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h9, 1'b1);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t4_read_addr", 32'(mem_addr), 32'h0);
    checkOutput("t4_capt_in_read", 32'(capturing), 32'h1);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h4, 1'b1);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t4_valid_early", 32'(rd_valid), 32'h0);
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t4_valid", 32'(rd_valid), 32'h1);
    checkOutput("t4_data", 32'(rd_data), 32'h2949);
    idleCycles(1);
    checkOutput("t4_no_we_yet", 32'(mem_we), 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h9, 1'b1);
    checkOutput("t4_we", 32'(mem_we), 32'h1);
    checkOutput("t4_addr", 32'(mem_addr), 32'h3);
    checkOutput("t4_wdata", 32'(mem_wdata), 32'h2949);
    idleCycles(4);
    checkOutput("t4_done_ok", 32'({wr_done, wr_ok}), 32'h3);

    // 5: corrupted write fails verification.
    corrupt = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd1, 4'h0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h5, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h5, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h5, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h5, 1'b1);
    checkOutput("t5_wdata", 32'(mem_wdata), 32'h5555);
    idleCycles(4);
    checkOutput("t5_done_bad", 32'({wr_done, wr_ok}), 32'h2);
    checkOutput("t5_mem_slot1", 32'(mem[1]), 32'h0);
    corrupt = 1'b0;

    // 6: read beats reconfig; then reset during VERIFY_WAIT.
    applyStimulus(1'b1, 2'd2, 1'b1, 2'd2, 4'h0, 1'b0);
    checkOutput("t6_read_first", 32'(capturing), 32'h0);
    checkOutput("t6_busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 4'h0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 4'h0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("t6_valid", 32'(rd_valid), 32'h1);
    checkOutput("t6_data", 32'(rd_data), 32'h7890);
    checkOutput("t6_not_capt_yet", 32'(capturing), 32'h0);
    idleCycles(1);
    checkOutput("t6_pending_capt", 32'(capturing), 32'h1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 4'h1, 1'b1);
    checkOutput("t6_we", 32'(mem_we), 32'h1);
    checkOutput("t6_addr", 32'(mem_addr), 32'h2);
    idleCycles(1);
    checkOutput("t6_vw_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    idleCycles(1);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    checkOutput("t6_rst_we", 32'(mem_we), 32'h0);
    checkOutput("t6_rst_addr", 32'(mem_addr), 32'h0);
    checkOutput("t6_rst_data", 32'(rd_data), 32'h0);
    checkOutput("t6_rst_flags", 32'({rd_valid, capturing, wr_done, wr_ok, bad_digit}), 32'h0);
    reset = 1'b1;
    idleCycles(4);
    checkOutput("t6_no_done", 32'({wr_done, busy}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/password_store_ctrl.md
Name: password_store_ctrl

Overview:
- Owns the password memory that backs the game's access check.
- Arbitrates between read requests from the access checker and password reconfiguration writes.
- Captures a new 4-digit BCD password, digit by digit, from the player switches.
- Writes the password to a selected slot, then reads it back to verify the write.

Parameters:
- DATA_W, 16, password word width (4 BCD digits, first digit in [15:12]).
- ADDR_W, 2, slot address width.
- RD_LAT, 2, memory read latency in clock cycles (address to valid mem_rdata); legal range 1..7.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- rd_req  in  1  level; read request from the access checker; held until rd_valid.
- rd_slot  in  ADDR_W  slot to read; sampled when the request is accepted.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DATA_W  word read back; holds its value until the next read.
- reconfig  in  1  one-cycle pulse; starts password capture.
- wr_slot  in  ADDR_W  target slot; sampled at the reconfig pulse.
- digit  in  4  BCD digit from the switches.
- digit_enter  in  1  one-cycle pulse; the current digit is entered.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.
- capturing  out  1  high while password capture is in progress.
- wr_done  out  1  one-cycle pulse; write-and-verify has finished.
- wr_ok  out  1  verify result; valid with wr_done and held until the next wr_done.
- bad_digit  out  1  one-cycle pulse; an entered digit was greater than 9.

Behaviour:
- Reset:
  - reset==0 at a clock edge: state IDLE; all outputs 0; internal digit index, pending-digit buffer, pending-reconfig flag and captured word all cleared.
  - Reset mid-operation aborts immediately; mem_we is 0 in the cycle after the reset edge.
- States: IDLE, CAPTURE, READ_WAIT, WRITE, VERIFY_WAIT, VERIFY.
- Read (accepted in IDLE or CAPTURE):
  - Acceptance edge: mem_addr<=rd_slot; save the return state; go to READ_WAIT with counter=RD_LAT.
  - Counter reaches 0: rd_data<=mem_rdata and rd_valid=1 for one cycle; return to the saved state.
  - rd_valid rises exactly RD_LAT+1 cycles after the acceptance edge.
  - rd_req still high in the cycle after rd_valid is treated as a new request.
- Arbitration:
  - In IDLE, rd_req has priority over reconfig.
  - A reconfig pulse that loses arbitration, or that arrives during READ_WAIT, sets the pending-reconfig flag; capture starts when READ_WAIT returns to IDLE.
- Capture:
  - Entering CAPTURE: index=0, capturing=1.
  - Each digit_enter with digit<=9 stores the digit at nibble [15-4*index : 12-4*index] and increments the index.
  - When the 4th digit is stored: go to WRITE.
  - digit>9: bad_digit pulse, index<=0, captured word<=0, stay in CAPTURE.
  - reconfig while in CAPTURE: restart capture (index 0); wr_slot is resampled.
- Digit buffering during a read:
  - A digit_enter during READ_WAIT (return state CAPTURE) is stored in a one-entry buffer and consumed on the first CAPTURE cycle.
  - Further pulses while the buffer is full are dropped.
- WRITE (1 cycle): mem_addr=slot, mem_wdata=captured word, mem_we=1; capturing<=0; go to VERIFY_WAIT.
- VERIFY_WAIT: mem_we=0, mem_addr=slot held; wait RD_LAT cycles; go to VERIFY.
- VERIFY: wr_ok<=(mem_rdata==captured word); wr_done=1 for one cycle; go to IDLE.
- Ignored inputs:
  - reconfig and rd_req during WRITE, VERIFY_WAIT and VERIFY are not serviced; rd_req is serviced after return to IDLE.
  - digit_enter in IDLE is ignored.
- mem_we is never high outside WRITE.

Test Plan:
1. RD_LAT=2, mem slot0=16'h2949; rd_req=1 with rd_slot=0 in IDLE -> mem_addr=0; rd_valid one cycle 3 cycles after the acceptance edge; rd_data=16'h2949.
2. reconfig with wr_slot=1; digits 1,2,3,4 -> single mem_we cycle with mem_addr=1, mem_wdata=16'h1234; wr_done with wr_ok=1 three cycles later; memory slot1=16'h1234.
3. Capture digits 5,6, then 4'hA -> bad_digit pulse, no mem_we; then 7,8,9,0 -> mem_wdata=16'h7890.
4. During capture after digits 2,9: rd_req slot0, with digit_enter(4) in READ_WAIT -> rd_valid/rd_data correct; then digit 9 -> mem_wdata=16'h2949.
5. Memory model corrupts the write (stores 16'h0000) -> wr_done with wr_ok=0.
6. rd_req and reconfig in the same IDLE cycle -> read completes first, then capturing=1; reset asserted during VERIFY_WAIT -> next cycle all outputs 0, state IDLE.
